seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised sequential multiplier: the clocked successor to the fixed 8-bit combinational array multiplier. It computes a WIDTH×WIDTH product in two's-complement (signed) or plain binary (unsigned) mode by iterative shift-add, one multiplier bit per clock. It trades latency for area, with a start/done handshake, so one multiplier can be shared by datapath blocks that cannot afford a full array.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal range 2..32.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `signed_mode`  input  1  1 = both operands two's-complement; 0 = both unsigned. Sampled with `start`.
- `a`  input  WIDTH  multiplicand. Sampled with `start`.
- `b`  input  WIDTH  multiplier. Sampled with `start`.
- `busy`  output  1  high while an operation is in progress (RUN).
- `done`  output  1  one-cycle pulse when `p` becomes valid.
- `p`  output  2*WIDTH  product. Held stable from `done` until the next accepted `start`.

## Operation
- FSM states:
  - IDLE: `busy`=0. `start`=1 latches `a`, `b` and `signed_mode`, clears the accumulator and iteration counter, and goes to RUN.
  - RUN: `busy`=1. Runs exactly WIDTH iterations, then goes to DONE.
  - DONE: `busy`=0, `done`=1 for one cycle, then returns to IDLE.
- Iteration i (0..WIDTH-1) examines `b[i]`:
  - If `b[i]`=1, the extended multiplicand is added at weight 2^i.
  - Signed mode: the multiplicand is sign-extended to 2*WIDTH. The iteration with i = WIDTH-1 subtracts instead of adds, because the MSB weight is negative.
  - Unsigned mode: the multiplicand is zero-extended and every iteration adds.
- All arithmetic is modulo 2^(2*WIDTH). The full product always fits, so there is no overflow flag.
- `p` is written only on the RUN→DONE transition. Intermediate accumulator values are never visible on `p`.
- `start` in RUN or DONE is ignored; there is no queuing. Operand changes after acceptance have no effect.
- The iteration counter is $clog2(WIDTH+1) bits wide and does not wrap within an operation.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `p`=0, accumulator=0, counter=0.
- Start accepted at edge E0 → `busy`=1 from E0 to E0+WIDTH.
- `done`=1 and `p` valid in the cycle after edge E0+WIDTH. Latency from accept to `done` is WIDTH+1 cycles (9 for WIDTH=8).
- The earliest next accept is on the edge where `done` is high is not allowed; it occurs at edge E0+WIDTH+2. Sustained throughput is one product per WIDTH+2 cycles.
- `rst` asserted in any state, including mid-RUN, returns every output to its reset value on the next edge. The partial result is discarded.
- `rst` and `start` both high: `rst` wins.

## Configuration
- `SEQ_MULT_SIGNED_EN`:
  - Defined: `signed_mode` is honoured as described above.
  - Undefined: the signed-handling logic (sign extension and final-iteration subtract) is not compiled. `signed_mode` is ignored and every operation is unsigned. The port remains present so instantiations do not change.

## Test plan
- WIDTH=8, unsigned: `a`=255, `b`=255, `start` pulse → `done` 9 cycles later with `p`=16'hFE01; `busy` high for exactly 8 cycles.
- WIDTH=8, signed: `a`=8'h80 (-128), `b`=8'h80 → `p`=16'h4000. Then `a`=8'hFF (-1), `b`=8'h7F → `p`=16'hFF81.
- Same inputs as the previous scenario, built without `SEQ_MULT_SIGNED_EN` and with `signed_mode`=1 → unsigned results: 16'h4000 and 16'h7E81.
- Hold `start` high while busy and change `a`/`b` mid-RUN → single `done`, result matches the operands originally latched; the next accept occurs 2 cycles after `done` rises.
- Assert `rst` at iteration 4 of 3×5 → next cycle `busy`=0, `done`=0, `p`=0. A fresh 3×5 then returns `p`=15.
- WIDTH=16 regression: 1000 random signed and unsigned operand pairs → `p` equals the reference product for every pair, and `done` arrives exactly 17 cycles after accept.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, one multiplier bit per clock.
// A start pulse in IDLE latches the operands, RUN performs WIDTH add
// iterations, and DONE presents the product with a single-cycle pulse.
//
// Handshake: a request is accepted on the rising edge where the FSM is in
// IDLE and start=1 (rst low). busy is high for exactly the WIDTH cycles of
// RUN. done is high for exactly one cycle, and p is valid in that cycle.
// p then holds its value until the next accepted request completes.
// start outside IDLE is ignored; requests are not queued.
//
// Build option: define SEQ_MULT_SIGNED_EN to honour signed_mode
// (two's-complement operands). Without it, every operation is unsigned
// and signed_mode is left unconnected internally.

module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p,
    output logic [1:0]           dbg_state
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;

    // Working registers for one operation.
    logic [PW-1:0]    mcand_q;   // extended multiplicand, shifted left each iteration
    logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right so bit 0 is the current bit
    logic             sgn_q;     // operation runs in two's-complement mode
    logic [PW-1:0]    acc_q;     // running partial sum
    logic [CW-1:0]    cnt_q;     // iteration index, 0..WIDTH

    logic [PW-1:0]    ext_a;     // multiplicand extended to product width at accept
    logic             sgn_in;    // mode captured at accept
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_nx;
    logic             last_iter;
    logic             accept;

`ifdef SEQ_MULT_SIGNED_EN
    // Signed operands are sign-extended so the shifted multiplicand keeps its
    // value modulo 2^PW; the MSB of the multiplier carries negative weight.
    assign ext_a  = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign sgn_in = signed_mode;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign ext_a  = {{WIDTH{1'b0}}, a};
    assign sgn_in = 1'b0;
`endif

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign dbg_state = state;

    // One shift-add step: add the current multiplicand when the multiplier
    // bit is set; the final signed iteration subtracts instead.
    always_comb begin
        addend = '0;
        acc_nx = acc_q;
        if (mplier_q[0]) begin
            addend = mcand_q;
        end
        if (sgn_q && last_iter) begin
            acc_nx = acc_q - addend;
        end else begin
            acc_nx = acc_q + addend;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate in RUN, publish p only at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            sgn_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p        <= '0;
        end else if (accept) begin
            mcand_q  <= ext_a;
            mplier_q <= b;
            sgn_q    <= sgn_in;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state == RUN) begin
            mcand_q  <= {mcand_q[PW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            acc_q    <= acc_nx;
            cnt_q    <= cnt_q + CW'(1);
            if (last_iter) begin
                p <= acc_nx;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: scoreboard bench for seq_mult (WIDTH=8). The driver pushes
// the arithmetic product and the accept edge number for every accepted
// request; a monitor pops and compares whenever done is high.

module tb_seq_mult;

    localparam int W  = 8;
    localparam int PW = 2 * W;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] p;
    logic [1:0]    dbg_state;

    logic [PW-1:0] exp_q[$];
    int            cyc_q[$];
    int            cyc;
    int            n_vec;
    int            n_err;
    int            busy_cnt;
    logic [PW-1:0] last_exp;

    seq_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .p           (p),
        .dbg_state   (dbg_state)
    );

    // Clock and edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer product, truncated to the product width.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint px;
        longint py;
        px = longint'(x);
        py = longint'(y);
        if (s && SIGNED_EN) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end
        return PW'(px * py);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, t);
        end
    endtask

    // Issue one request from IDLE; returns just after the accept edge.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        wait_idle();
        a           = x;
        b           = y;
        signed_mode = s;
        start       = 1'b1;
        exp_q.push_back(ref_prod(x, y, s));
        cyc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = W'($urandom());
        b           = W'($urandom());
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    // Monitor: compares every done against the scoreboard, plus busy length,
    // latency from accept, and p holding its last published value.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            last_exp = '0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("busy_len", 64'(busy_cnt), 64'(W));
                busy_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: p=%0h with no request pending", p);
                end else begin
                    logic [PW-1:0] e;
                    int            c;
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("product", 64'(p), 64'(e));
                    check("latency", 64'(cyc - c), 64'(W));
                    last_exp = e;
                end
            end else begin
                check("p_hold", 64'(p), 64'(last_exp));
            end
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        busy_cnt    = 0;
        last_exp    = '0;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;

        // Directed corner cases.
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h80, 8'h80, 1'b1);
        do_op(8'hFF, 8'h7F, 1'b1);
        do_op(8'h00, 8'hAB, 1'b0);
        do_op(8'h7F, 8'h80, 1'b1);
        do_op(8'h01, 8'hFF, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0);

        // start held through RUN with operands changing; only the latched
        // pair counts, and the held start is re-accepted two cycles after done.
        begin
            logic [W-1:0] x2;
            logic [W-1:0] y2;
            logic         s2;
            int           t;
            wait_idle();
            a           = 8'hC3;
            b           = 8'h5A;
            signed_mode = 1'b1;
            start       = 1'b1;
            exp_q.push_back(ref_prod(8'hC3, 8'h5A, 1'b1));
            cyc_q.push_back(cyc + 1);
            @(posedge clk);
            t = 0;
            @(negedge clk);
            while (!done && t < 50) begin
                a           = W'($urandom());
                b           = W'($urandom());
                signed_mode = 1'($urandom_range(0, 1));
                @(negedge clk);
                t++;
            end
            x2 = W'($urandom());
            y2 = W'($urandom());
            s2 = 1'($urandom_range(0, 1));
            a           = x2;
            b           = y2;
            signed_mode = s2;
            exp_q.push_back(ref_prod(x2, y2, s2));
            cyc_q.push_back(cyc + 2);
            repeat (2) @(posedge clk);
            #1;
            start = 1'b0;
        end

        // Reset in the middle of 3x5 discards the partial result.
        do_op(8'd3, 8'd5, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_p", 64'(p), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(8'd3, 8'd5, 1'b0);

        // Random regression, both modes.
        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard.
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            repeat (2) @(negedge clk);
            check("sb_empty", 64'(exp_q.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
